// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch front end. Drives the read port of a combinational
//   instruction memory, keeps the fetch PC, and buffers each fetched word
//   together with its PC in a small FIFO. The FIFO head goes to the decode
//   stage through a valid/ready handshake. A redirect from execute flushes the
//   buffer and restarts fetch at the new target.
//
// Parameters
//   PC_W        program counter width (byte address)
//   IM_AW       instruction memory word-address width, IM_addr = pc[IM_AW+1:2]
//   RESET_PC    PC loaded on reset (bits [1:0] must be 0)
//   FIFO_DEPTH  instruction buffer entries (power of 2, >= 2)
//
// Ports
//   clk             in   clock, all state on the rising edge
//   rst             in   asynchronous reset, active-low
//   IM_read         out  read strobe to instruction memory
//   IM_addr         out  word address to instruction memory
//   IM_out          in   read data, valid in the same cycle as IM_read
//   if_valid        out  head instruction valid to decode
//   if_ready        in   decode accepts the head this cycle
//   if_inst         out  head instruction word (0 when buffer empty)
//   if_pc           out  PC of head instruction (0 when buffer empty)
//   redirect_valid  in   flush and redirect fetch
//   redirect_pc     in   redirect target, bits [1:0] ignored
//
// Optional build macro
//   IF_PERF_EN  adds perf_fetch_cnt[31:0] (cycles with IM_read=1) and
//               perf_flush_cnt[15:0] (redirect cycles); both wrap, reset to 0.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int unsigned     PC_W       = 32,
  parameter int unsigned     IM_AW      = 14,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              IM_read,
  output logic [IM_AW-1:0]  IM_addr,
  input  logic [31:0]       IM_out,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_inst,
  output logic [PC_W-1:0]   if_pc,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc
`ifdef IF_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  localparam int unsigned   PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned   CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Buffer storage: data only, never reset; occupancy is tracked by cnt_q.
  logic [31:0]       inst_mem_q [FIFO_DEPTH];
  logic [PC_W-1:0]   pc_mem_q   [FIFO_DEPTH];

  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              fetch;
  logic [PC_W-1:0]   redir_target;

  // Low two bits of the target are forced to zero (word-aligned fetch).
  assign redir_target = redirect_pc & ~PC_W'(3);

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_C);

  // A redirect cycle hides the head so decode never consumes a wrong-path word.
  assign if_valid = !fifo_empty && !redirect_valid;
  assign pop      = if_valid && if_ready;

  assign if_inst  = fifo_empty ? '0 : inst_mem_q[rd_ptr_q];
  assign if_pc    = fifo_empty ? '0 : pc_mem_q[rd_ptr_q];

  // ---- fetch control FSM -------------------------------------------------
  always_comb begin
    state_d = state_q;
    fetch   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        // A full buffer can still accept a word if the head leaves this cycle.
        if (!fifo_full || pop) begin
          fetch = 1'b1;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (pop) begin
          fetch   = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (redirect_valid) begin
      fetch   = 1'b0;
      state_d = S_FETCH;
    end
  end

  assign IM_read = fetch;
  assign IM_addr = fetch ? pc_q[IM_AW+1:2] : '0;

  // ---- next-state for PC and buffer pointers -----------------------------
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (redirect_valid) begin
      pc_d     = redir_target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (fetch) begin
        pc_d     = pc_q + PC_W'(4);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(fetch) - CNT_W'(pop);
    end
  end

  // ---- state registers ---------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---- buffer write ------------------------------------------------------
  always_ff @(posedge clk) begin
    if (fetch) begin
      inst_mem_q[wr_ptr_q] <= IM_out;
      pc_mem_q[wr_ptr_q]   <= pc_q;
    end
  end

`ifdef IF_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [15:0] perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (fetch) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (redirect_valid) begin
        perf_flush_q <= perf_flush_q + 16'd1;
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed scenarios followed by randomized traffic, all compared against a
//   queue-based reference model of the fetch buffer. The instruction memory is
//   modelled as IM[i] = 0xA000_0000 + i.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        im_read;
  logic [13:0] im_addr;
  logic [31:0] im_out;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        rv = 1'b0;
  logic [31:0] rpc = '0;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetch;
  logic [15:0] perf_flush;
`endif

  always #5 clk = ~clk;

  assign im_out = 32'hA000_0000 + 32'(im_addr);

  if_fetch_unit #(
    .PC_W      (32),
    .IM_AW     (14),
    .RESET_PC  (32'h0),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst_n),
    .IM_read       (im_read),
    .IM_addr       (im_addr),
    .IM_out        (im_out),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .redirect_valid(rv),
    .redirect_pc   (rpc)
`ifdef IF_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch),
    .perf_flush_cnt(perf_flush)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_bubble;
  logic [31:0] m_fetch;
  logic [15:0] m_flush;

  // Last observed outputs, for directed checks
  logic        o_valid, o_read;
  logic [13:0] o_addr;
  logic [31:0] o_inst, o_pc;

  task automatic model_reset();
    mq.delete();
    m_pc     = 32'h0;
    m_bubble = 1'b1;
    m_fetch  = '0;
    m_flush  = '0;
  endtask

  // One clock cycle: entered just after a falling edge, returns at the next.
  task automatic step(input bit v, input logic [31:0] tp, input bit rdy);
    bit          e_valid, e_pop, e_read;
    logic [31:0] e_inst, e_pc;
    logic [13:0] e_addr;
    ent_t        ne;
    rv = v; rpc = tp; if_ready = rdy;
    #1;
    e_inst = '0; e_pc = '0;
    if (mq.size() > 0) begin
      e_inst = mq[0].inst;
      e_pc   = mq[0].pc;
    end
    e_valid = (mq.size() > 0) && !v;
    e_pop   = e_valid && rdy;
    e_read  = !v && !m_bubble && ((mq.size() < DEPTH) || e_pop);
    e_addr  = e_read ? m_pc[15:2] : 14'h0;

    o_valid = if_valid; o_read = im_read; o_addr = im_addr;
    o_inst  = if_inst;  o_pc = if_pc;
    chk_eq("if_valid", 64'(o_valid), 64'(e_valid));
    chk_eq("if_inst",  64'(o_inst),  64'(e_inst));
    chk_eq("if_pc",    64'(o_pc),    64'(e_pc));
    chk_eq("IM_read",  64'(o_read),  64'(e_read));
    chk_eq("IM_addr",  64'(o_addr),  64'(e_addr));
`ifdef IF_PERF_EN
    chk_eq("perf_fetch", 64'(perf_fetch), 64'(m_fetch));
    chk_eq("perf_flush", 64'(perf_flush), 64'(m_flush));
    m_fetch = m_fetch + 32'(e_read);
    m_flush = m_flush + 16'(v);
`endif

    if (v) begin
      mq.delete();
      m_pc = tp & ~32'h3;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (e_read) begin
        ne.inst = 32'hA000_0000 + 32'(m_pc[15:2]);
        ne.pc   = m_pc;
        mq.push_back(ne);
        m_pc = m_pc + 32'd4;
      end
    end
    m_bubble = 1'b0;
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks outputs right away, releases at a falling edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0; rv = 1'b0; if_ready = 1'b0;
    #1;
    chk_eq({tag, "_valid"}, 64'(if_valid), 64'h0);
    chk_eq({tag, "_read"},  64'(im_read),  64'h0);
    chk_eq({tag, "_addr"},  64'(im_addr),  64'h0);
    chk_eq({tag, "_inst"},  64'(if_inst),  64'h0);
    chk_eq({tag, "_pc"},    64'(if_pc),    64'h0);
`ifdef IF_PERF_EN
    chk_eq({tag, "_pfetch"}, 64'(perf_fetch), 64'h0);
    chk_eq({tag, "_pflush"}, 64'(perf_flush), 64'h0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    @(negedge clk);

    // Test 1: reset latency and streaming throughput
    do_reset("t1_rst");
    step(0, 0, 1); chk_eq("t1_c0_read", 64'(o_read), 64'h0);
    step(0, 0, 1); chk_eq("t1_c1_read", 64'(o_read), 64'h1);
                   chk_eq("t1_c1_addr", 64'(o_addr), 64'h0);
    step(0, 0, 1); chk_eq("t1_c2_valid", 64'(o_valid), 64'h1);
                   chk_eq("t1_c2_inst",  64'(o_inst),  64'hA000_0000);
                   chk_eq("t1_c2_pc",    64'(o_pc),    64'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    chk_eq("t1_c7_pc", 64'(o_pc), 64'h14);

    // Test 2: backpressure fills the buffer, stream resumes without gaps
    do_reset("t2_rst");
    step(0, 0, 1); step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0); chk_eq("t2_full_read", 64'(o_read), 64'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk_eq("t2_hold_inst", 64'(o_inst), 64'hA000_0000);
    step(0, 0, 1); chk_eq("t2_resume_pc0", 64'(o_pc), 64'h0);
    step(0, 0, 1); chk_eq("t2_resume_pc4", 64'(o_pc), 64'h4);
    step(0, 0, 0);

    // Test 3: redirect while full, unaligned target
    step(1, 32'h0000_0103, 1); chk_eq("t3_valid", 64'(o_valid), 64'h0);
                               chk_eq("t3_read",  64'(o_read),  64'h0);
    step(0, 0, 1); chk_eq("t3_addr", 64'(o_addr), 64'h40);
    step(0, 0, 1); chk_eq("t3_pc",   64'(o_pc),   64'h100);

    // Test 4: back-to-back redirects, last one wins
    step(1, 32'h200, 1);
    step(1, 32'h300, 1);
    step(0, 0, 1);
    step(0, 0, 1); chk_eq("t4_valid", 64'(o_valid), 64'h1);
                   chk_eq("t4_pc",    64'(o_pc),    64'h300);

    // Test 5: PC wrap
    step(1, 32'hFFFF_FFFC, 1);
    step(0, 0, 1);
    step(0, 0, 1); chk_eq("t5_pc_top",  64'(o_pc), 64'hFFFF_FFFC);
    step(0, 0, 1); chk_eq("t5_pc_wrap", 64'(o_pc), 64'h0);

    // Test 6: reset while full, then behaves like test 1
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    do_reset("t6_rst");
    step(0, 0, 1); chk_eq("t6_c0_read", 64'(o_read), 64'h0);
    step(0, 0, 1); chk_eq("t6_c1_read", 64'(o_read), 64'h1);
    step(0, 0, 1); chk_eq("t6_c2_inst", 64'(o_inst), 64'hA000_0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          v, r;
      logic [31:0] t;
      if (i == 1500) do_reset("rnd_rst");
      v = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 3))
        0:       t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        1:       t = 32'($urandom_range(0, 255));
        default: t = $urandom;
      endcase
      if ((i / 64) % 4 == 3) r = ($urandom_range(0, 3) == 0);
      else                   r = ($urandom_range(0, 3) != 0);
      step(v, t, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
